quad_decoder: RTL and testbench

- Decoder end of the up/down counting path. Takes raw two-phase quadrature signals (A/B, 90° apart) from an external encoder.
- Produces per-step enable/direction strobes plus a signed-free wrap-around position count, in the same enable/direction/out style as the existing up/down counter.
- Sits between pad inputs and downstream position/control logic. Includes input synchronization and glitch filtering.

---
 rtl/quad_decoder_if.sv | 28 ++
 rtl/quad_decoder.sv | 182 ++++++++++++++++++
 tb/tb_quad_decoder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/quad_decoder_if.sv
// Signal bundle between the quadrature pads/control side and the decoder.
// The decoder takes the slave view; the driver of the pins and the consumer of the strobes take the master view.
interface quad_decoder_if #(
    parameter int WIDTH = 7
);
    logic             a_in;
    logic             b_in;
    logic             enable;
    logic             clear;
    logic             step_valid;
    logic             step_dir;
    logic [WIDTH-1:0] count;
    logic             err;
    logic             wrap;
    // Accepted {a,b} phase and init flag, brought out for observation only.
    logic [1:0]       phase_dbg;
    logic             init_dbg;

    modport master (
        output a_in, b_in, enable, clear,
        input  step_valid, step_dir, count, err, wrap, phase_dbg, init_dbg
    );

    modport slave (
        input  a_in, b_in, enable, clear,
        output step_valid, step_dir, count, err, wrap, phase_dbg, init_dbg
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and glitch-filters raw A/B phases, tracks the
// accepted phase and turns legal transitions into step strobes and a wrapping count.
module quad_decoder #(
    parameter int WIDTH       = 7,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic           clk,
    input  logic           rst,
    quad_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        P00 = 2'b00,
        P01 = 2'b01,
        P11 = 2'b11,
        P10 = 2'b10
    } phase_e;

    localparam int               CNT_W     = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    // Gray phase to position along the up sequence 00,01,11,10.
    function automatic logic [1:0] phase_idx(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
    logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
    logic [1:0]             s;

    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    phase_e           phase_q, phase_d;
    logic             init_q, init_d;

    logic [1:0]       cand_new;
    logic [CNT_W-1:0] cnt_new;
    logic [1:0]       phase_delta;

    logic ev_step_q, ev_step_d;
    logic ev_dir_q, ev_dir_d;
    logic ev_err_q, ev_err_d;

    logic             step_valid_q, step_valid_d;
    logic             step_dir_q, step_dir_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        sync_a_d = {sync_a_q[SYNC_STAGES-2:0], bus.a_in};
        sync_b_d = {sync_b_q[SYNC_STAGES-2:0], bus.b_in};
    end

    assign s = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

    // Filter plus phase FSM. While the init flag is set the "equals accepted
    // phase" shortcut is bypassed, so a resting encoder (even at 00) is loaded.
    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        init_d      = init_q;
        ev_step_d   = 1'b0;
        ev_dir_d    = 1'b0;
        ev_err_d    = 1'b0;
        cand_new    = cand_q;
        cnt_new     = cnt_q;
        phase_delta = 2'd0;

        if (!init_q && (s == phase_q)) begin
            cnt_d = '0;
        end else begin
            if (s != cand_q) begin
                cand_new = s;
                cnt_new  = CNT_ONE;
            end else begin
                cand_new = cand_q;
                cnt_new  = cnt_q + CNT_ONE;
            end
            cand_d = cand_new;

            if (cnt_new == FILT_LAST) begin
                cnt_d       = '0;
                phase_d     = phase_e'(cand_new);
                init_d      = 1'b0;
                phase_delta = phase_idx(cand_new) - phase_idx(phase_q);
                if (!init_q) begin
                    case (phase_delta)
                        2'd1: begin
                            ev_step_d = 1'b1;
                            ev_dir_d  = 1'b1;
                        end
                        2'd3: begin
                            ev_step_d = 1'b1;
                            ev_dir_d  = 1'b0;
                        end
                        2'd2:    ev_err_d = 1'b1;
                        default: ;
                    endcase
                end
            end else begin
                cnt_d = cnt_new;
            end
        end
    end

    // Output stage: enable and clear are sampled here, one edge after acceptance.
    always_comb begin
        step_valid_d = 1'b0;
        step_dir_d   = step_dir_q;
        count_d      = count_q;
        err_d        = ev_err_q;
        wrap_d       = 1'b0;

        if (ev_step_q) begin
            step_dir_d = ev_dir_q;
            if (bus.enable) begin
                step_valid_d = 1'b1;
                if (ev_dir_q) begin
                    count_d = count_q + COUNT_ONE;
                    wrap_d  = (count_q == COUNT_MAX);
                end else begin
                    count_d = count_q - COUNT_ONE;
                    wrap_d  = (count_q == '0);
                end
            end
        end

        if (bus.clear) begin
            count_d = '0;
            wrap_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a_q     <= '0;
            sync_b_q     <= '0;
            cand_q       <= 2'b00;
            cnt_q        <= '0;
            phase_q      <= P00;
            init_q       <= 1'b1;
            ev_step_q    <= 1'b0;
            ev_dir_q     <= 1'b0;
            ev_err_q     <= 1'b0;
            step_valid_q <= 1'b0;
            step_dir_q   <= 1'b0;
            count_q      <= '0;
            err_q        <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            sync_a_q     <= sync_a_d;
            sync_b_q     <= sync_b_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            init_q       <= init_d;
            ev_step_q    <= ev_step_d;
            ev_dir_q     <= ev_dir_d;
            ev_err_q     <= ev_err_d;
            step_valid_q <= step_valid_d;
            step_dir_q   <= step_dir_d;
            count_q      <= count_d;
            err_q        <= err_d;
            wrap_q       <= wrap_d;
        end
    end

    assign bus.step_valid = step_valid_q;
    assign bus.step_dir   = step_dir_q;
    assign bus.count      = count_q;
    assign bus.err        = err_q;
    assign bus.wrap       = wrap_q;
    assign bus.phase_dbg  = phase_q;
    assign bus.init_dbg   = init_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: drives quadrature phases, predicts every
// strobe event into a queue and checks the DUT against it.
module tb_quad_decoder;
    localparam int WIDTH = 7;
    localparam int SYNC  = 2;
    localparam int FILT  = 3;
    localparam int HOLD  = 10;
    localparam int W     = 11;

    logic clk;
    logic rst;

    quad_decoder_if #(.WIDTH(WIDTH)) bus ();

    quad_decoder #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC),
        .FILTER_LEN(FILT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    logic [1:0]       pins;
    logic [WIDTH-1:0] model_count;
    logic             model_dir;
    logic             en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ev(input logic sv, input logic er, input logic dir,
                                        input logic wr, input logic [WIDTH-1:0] c);
        return {sv, er, dir, wr, c};
    endfunction

    function automatic logic [1:0] next_up(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] next_dn(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // driver tasks
    task automatic drive_pins(input logic [1:0] ab);
        bus.a_in = ab[1];
        bus.b_in = ab[0];
        pins = ab;
    endtask

    task automatic expect_step(input logic up);
        logic wr;
        model_dir = up;
        if (en) begin
            wr = up ? (model_count == {WIDTH{1'b1}}) : (model_count == '0);
            model_count = up ? model_count + 1'b1 : model_count - 1'b1;
            exp_q.push_back(ev(1'b1, 1'b0, up, wr, model_count));
        end
    endtask

    task automatic do_step(input logic up);
        @(negedge clk);
        drive_pins(up ? next_up(pins) : next_dn(pins));
        expect_step(up);
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic do_jump(input logic [1:0] ab);
        @(negedge clk);
        drive_pins(ab);
        exp_q.push_back(ev(1'b0, 1'b1, model_dir, 1'b0, model_count));
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_count"}, bus.count, '0);
        check({tag, "_step_valid"}, bus.step_valid, 1'b0);
        check({tag, "_step_dir"}, bus.step_dir, 1'b0);
        check({tag, "_err"}, bus.err, 1'b0);
        check({tag, "_wrap"}, bus.wrap, 1'b0);
    endtask

    // scoreboard
    always @(negedge clk) begin
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        if (rst && (bus.step_valid || bus.err || bus.wrap)) begin
            obs = {bus.step_valid, bus.err, bus.step_dir, bus.wrap, bus.count};
            check("event_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check("event", obs, exp);
            end
        end
    end

    initial begin
        int lat;
        rst = 1'b1;
        en = 1'b1;
        bus.enable = 1'b1;
        bus.clear = 1'b0;
        drive_pins(2'b00);
        model_count = '0;
        model_dir = 1'b0;

        // Reset with encoder at 00.
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;
        repeat (HOLD) @(negedge clk);

        // First up step with latency measurement, then three more.
        @(negedge clk);
        drive_pins(next_up(pins));
        expect_step(1'b1);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (lat == 0 && bus.step_valid) lat = i;
        end
        check("latency_edge", lat, 1 + SYNC + FILT);
        for (int i = 0; i < 3; i++) do_step(1'b1);
        check("count_after_up", bus.count, 4);
        check("dir_after_up", bus.step_dir, 1'b1);

        // Down through zero: 3,2,1,0,127 with wrap on the last.
        for (int i = 0; i < 5; i++) do_step(1'b0);
        check("count_after_down", bus.count, 127);
        check("dir_after_down", bus.step_dir, 1'b0);

        // Two-cycle glitch on a_in is filtered out.
        @(negedge clk);
        bus.a_in = ~pins[1];
        repeat (2) @(negedge clk);
        bus.a_in = pins[1];
        repeat (HOLD) @(negedge clk);
        check("count_after_glitch", bus.count, 127);
        check("phase_after_glitch", bus.phase_dbg, pins);

        // Up wrap 127->0, illegal jump 00->11, then legal 11->10.
        do_step(1'b1);
        do_jump(2'b11);
        check("count_after_err", bus.count, 0);
        do_step(1'b1);
        check("count_after_recover", bus.count, 1);

        // Reset with encoder resting at 11; first step must not be an error.
        @(negedge clk);
        rst = 1'b0;
        drive_pins(2'b11);
        model_count = '0;
        model_dir = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_at_11");
        rst = 1'b1;
        repeat (HOLD) @(negedge clk);
        check("init_cleared", bus.init_dbg, 1'b0);
        do_step(1'b1);
        do_step(1'b1);
        do_step(1'b0);
        check("count_before_freeze", bus.count, 1);
        check("dir_before_freeze", bus.step_dir, 1'b0);

        // enable low: count frozen, direction still tracked.
        en = 1'b0;
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) do_step(1'b1);
        check("count_frozen", bus.count, 1);
        check("dir_frozen", bus.step_dir, 1'b1);

        // enable and clear land on the same edge as a step's output.
        @(negedge clk);
        drive_pins(next_up(pins));
        model_dir = 1'b1;
        model_count = '0;
        exp_q.push_back(ev(1'b1, 1'b0, 1'b1, 1'b0, '0));
        repeat (SYNC + FILT) @(negedge clk);
        en = 1'b1;
        bus.enable = 1'b1;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        repeat (HOLD) @(negedge clk);
        check("count_after_clear", bus.count, 0);
        do_step(1'b1);
        do_step(1'b1);
        check("count_before_rst", bus.count, 2);

        // Asynchronous reset mid-transition clears outputs without a clock edge.
        @(negedge clk);
        drive_pins(next_up(pins));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_idle_outputs("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_count = '0;
        model_dir = 1'b0;
        repeat (HOLD + 5) @(negedge clk);
        check("count_after_rst_release", bus.count, 0);
        check("phase_after_rst_release", bus.phase_dbg, pins);

        // final report
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
